// File: rtl/traffic_ctrl_gen_if.sv
// Signal bundle between the intersection controller and its environment:
// pedestrian buttons and flash request in, signal heads and monitor outputs back.
interface traffic_ctrl_gen_if;
  logic [1:0] ped_req;
  logic       flash_en;
  logic [1:0] car_light_a;
  logic [1:0] car_light_b;
  logic [1:0] hmn_light_a;
  logic [1:0] hmn_light_b;
  logic [3:0] phase;
  logic [1:0] ped_ack;

  modport master (
    output ped_req,
    output flash_en,
    input  car_light_a,
    input  car_light_b,
    input  hmn_light_a,
    input  hmn_light_b,
    input  phase,
    input  ped_ack
  );

  modport slave (
    input  ped_req,
    input  flash_en,
    output car_light_a,
    output car_light_b,
    output hmn_light_a,
    output hmn_light_b,
    output phase,
    output ped_ack
  );
endinterface

// File: rtl/traffic_ctrl_gen.sv
// Two-approach intersection signal controller with tick prescaler, optional
// left-turn phases, pedestrian actuation and a night-flash mode.
// Lights, phase and ped_ack are decodes of registered state only.
module traffic_ctrl_gen #(
  parameter int TICK_DIV = 1,
  parameter int CNT_W    = 8,
  parameter int T_ALLRED = 1,
  parameter int T_GREEN  = 14,
  parameter int T_BLINK  = 6,
  parameter int T_YELLOW = 2,
  parameter int T_LEFT   = 10,
  parameter int LEFT_EN  = 1,
  parameter int PED_ACT  = 0,
  parameter int START_B  = 0
) (
  input  logic                clk,
  input  logic                rst,
  traffic_ctrl_gen_if.slave   bus
);

  localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  localparam logic [3:0] S_RED_A  = 4'd0;
  localparam logic [3:0] S_A_GO   = 4'd1;
  localparam logic [3:0] S_A_CLR  = 4'd2;
  localparam logic [3:0] S_A_YEL  = 4'd3;
  localparam logic [3:0] S_A_LEFT = 4'd4;
  localparam logic [3:0] S_A_LYEL = 4'd5;
  localparam logic [3:0] S_RED_B  = 4'd6;
  localparam logic [3:0] S_B_GO   = 4'd7;
  localparam logic [3:0] S_B_CLR  = 4'd8;
  localparam logic [3:0] S_B_YEL  = 4'd9;
  localparam logic [3:0] S_B_LEFT = 4'd10;
  localparam logic [3:0] S_B_LYEL = 4'd11;
  localparam logic [3:0] S_FLASH  = 4'd12;
  localparam logic [3:0] S_INIT   = (START_B != 0) ? S_RED_B : S_RED_A;

  localparam logic [1:0] CAR_RED   = 2'b00;
  localparam logic [1:0] CAR_GREEN = 2'b01;
  localparam logic [1:0] CAR_YEL   = 2'b10;
  localparam logic [1:0] CAR_LEFT  = 2'b11;
  localparam logic [1:0] HMN_RED   = 2'b00;
  localparam logic [1:0] HMN_WALK  = 2'b01;
  localparam logic [1:0] HMN_BLINK = 2'b10;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       state_q, state_d;
  logic [1:0]       latch_q, latch_d;
  logic [1:0]       served_q, served_d;
  logic [1:0]       ack_q, ack_d;
  logic             tick_s;
  logic             last_s;
  logic             side_s;

  // Final tick-count value of each timed phase (duration minus one).
  function automatic logic [CNT_W-1:0] last_count(input logic [3:0] st);
    case (st)
      S_RED_A, S_RED_B:                     last_count = CNT_W'(T_ALLRED - 1);
      S_A_GO, S_B_GO:                       last_count = CNT_W'(T_GREEN - 1);
      S_A_CLR, S_B_CLR:                     last_count = CNT_W'(T_BLINK - 1);
      S_A_YEL, S_B_YEL, S_A_LYEL, S_B_LYEL: last_count = CNT_W'(T_YELLOW - 1);
      S_A_LEFT, S_B_LEFT:                   last_count = CNT_W'(T_LEFT - 1);
      default:                              last_count = {CNT_W{1'b0}};
    endcase
  endfunction

  // Successor of a non-red, non-flash phase; the yellow after green skips
  // straight to the other red when left arrows are disabled.
  function automatic logic [3:0] seq_next(input logic [3:0] st);
    case (st)
      S_A_GO:   seq_next = S_A_CLR;
      S_A_CLR:  seq_next = S_A_YEL;
      S_A_YEL:  seq_next = (LEFT_EN != 0) ? S_A_LEFT : S_RED_B;
      S_A_LEFT: seq_next = S_A_LYEL;
      S_A_LYEL: seq_next = S_RED_B;
      S_B_GO:   seq_next = S_B_CLR;
      S_B_CLR:  seq_next = S_B_YEL;
      S_B_YEL:  seq_next = (LEFT_EN != 0) ? S_B_LEFT : S_RED_A;
      S_B_LEFT: seq_next = S_B_LYEL;
      S_B_LYEL: seq_next = S_RED_A;
      default:  seq_next = S_RED_A;
    endcase
  endfunction

  // Free-running prescaler producing one timing tick every TICK_DIV cycles.
  always_comb begin
    tick_s = (pre_q == PRE_MAX);
    if (tick_s) begin
      pre_d = {PRE_W{1'b0}};
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Phase sequencing, flash entry/exit and pedestrian latch/service decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    ack_d    = 2'b00;
    side_s   = (state_q == S_RED_B);
    last_s   = (cnt_q == last_count(state_q));
    if (PED_ACT != 0) begin
      latch_d = latch_q | bus.ped_req;
    end else begin
      latch_d = 2'b00;
    end

    if (!tick_s) begin
      state_d = state_q;
    end else if (state_q == S_FLASH) begin
      // FLASH counts ticks for the yellow/red alternation until released.
      if (bus.flash_en) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = S_RED_A;
        cnt_d   = {CNT_W{1'b0}};
      end
    end else if (!last_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
      if ((state_q == S_RED_A) || (state_q == S_RED_B)) begin
        if (bus.flash_en) begin
          state_d = S_FLASH;
        end else begin
          state_d = state_q + 4'd1;
          if (PED_ACT != 0) begin
            // A request in this very cycle counts and is consumed, not re-latched.
            served_d[side_s] = latch_q[side_s] | bus.ped_req[side_s];
            ack_d[side_s]    = latch_q[side_s] | bus.ped_req[side_s];
            latch_d[side_s]  = 1'b0;
          end else begin
            served_d[side_s] = 1'b1;
          end
        end
      end else begin
        state_d = seq_next(state_q);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= {PRE_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      state_q  <= S_INIT;
      latch_q  <= 2'b00;
      served_q <= 2'b00;
      ack_q    <= 2'b00;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      latch_q  <= latch_d;
      served_q <= served_d;
      ack_q    <= ack_d;
    end
  end

  // Decode signal heads, phase and acknowledge from registered state.
  always_comb begin
    bus.car_light_a = CAR_RED;
    bus.car_light_b = CAR_RED;
    bus.hmn_light_a = HMN_RED;
    bus.hmn_light_b = HMN_RED;
    bus.phase       = state_q;
    bus.ped_ack     = ack_q;
    case (state_q)
      S_A_GO: begin
        bus.car_light_a = CAR_GREEN;
        bus.hmn_light_a = served_q[0] ? HMN_WALK : HMN_RED;
      end
      S_A_CLR: begin
        bus.car_light_a = CAR_GREEN;
        bus.hmn_light_a = served_q[0] ? HMN_BLINK : HMN_RED;
      end
      S_A_YEL, S_A_LYEL: bus.car_light_a = CAR_YEL;
      S_A_LEFT:          bus.car_light_a = CAR_LEFT;
      S_B_GO: begin
        bus.car_light_b = CAR_GREEN;
        bus.hmn_light_b = served_q[1] ? HMN_WALK : HMN_RED;
      end
      S_B_CLR: begin
        bus.car_light_b = CAR_GREEN;
        bus.hmn_light_b = served_q[1] ? HMN_BLINK : HMN_RED;
      end
      S_B_YEL, S_B_LYEL: bus.car_light_b = CAR_YEL;
      S_B_LEFT:          bus.car_light_b = CAR_LEFT;
      S_FLASH: begin
        bus.car_light_a = cnt_q[0] ? CAR_RED : CAR_YEL;
        bus.car_light_b = cnt_q[0] ? CAR_RED : CAR_YEL;
      end
      default: bus.phase = state_q;
    endcase
  end

endmodule

// File: doc/traffic_ctrl_gen.md
# traffic_ctrl_gen

Parametrised two-approach intersection signal controller, next generation of the fixed 69-cycle single-mode sequencer. It generalises phase durations, adds a tick prescaler and optional left-turn phases, and adds pedestrian push-button actuation and a night-flash mode. It drives the car and pedestrian heads for approaches A and B and exports the current phase for monitoring.

## Interface
- TICK_DIV, 1: clock cycles per timing tick (≥1).
- CNT_W, 8: width of the phase tick counter. Every T_* must be in 1..2^CNT_W−1.
- T_ALLRED, 1: all-red clearance ticks before each approach's green.
- T_GREEN, 14: car-green ticks with steady pedestrian walk.
- T_BLINK, 6: further car-green ticks with blinking pedestrian walk.
- T_YELLOW, 2: ticks for each yellow phase.
- T_LEFT, 10: left-arrow ticks.
- LEFT_EN, 1: 0 skips the left-arrow phases and the yellows after them.
- PED_ACT, 0: 1 grants walk only on a latched request. 0 grants walk every cycle.
- START_B, 0: 1 makes reset enter RED_B instead of RED_A.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- ped_req, in, 2: pedestrian buttons. Bit 0 requests the crosswalk served with A, bit 1 the one served with B. A single-cycle pulse is enough.
- flash_en, in, 1: level request for night flashing.
- car_light_a, out, 2: car head A. 00 red, 01 green, 10 yellow, 11 left arrow.
- car_light_b, out, 2: car head B, same encoding.
- hmn_light_a, out, 2: walk head for the crosswalk served with A. 00 red, 01 walk, 10 blink.
- hmn_light_b, out, 2: walk head for the crosswalk served with B, same encoding.
- phase, out, 4: current state encoding.
- ped_ack, out, 2: one-cycle pulse when a latched request is consumed.

## Operation
- Phase encodings:
  - 0 RED_A, 1 A_GO, 2 A_CLR, 3 A_YEL, 4 A_LEFT, 5 A_LYEL
  - 6 RED_B, 7 B_GO, 8 B_CLR, 9 B_YEL, 10 B_LEFT, 11 B_LYEL
  - 12 FLASH
- Phase durations:
  - RED_x: T_ALLRED. x_GO: T_GREEN. x_CLR: T_BLINK.
  - x_YEL: T_YELLOW. x_LEFT: T_LEFT. x_LYEL: T_YELLOW.
- Phase order:
  - Normal: RED_A→A_GO→A_CLR→A_YEL→A_LEFT→A_LYEL→RED_B→B_GO→…→B_LYEL→RED_A.
  - LEFT_EN=0: x_YEL→next RED phase.
- Light decode (side x = the approach being served, other = the other approach):
  - RED_x: all heads red.
  - x_GO: car_x green, hmn_x walk.
  - x_CLR: car_x green, hmn_x blink.
  - x_YEL and x_LYEL: car_x yellow.
  - x_LEFT: car_x left arrow.
  - The other approach's car head and walk head are red in every side-x phase.
  - Walk/blink is shown only if side x is served (see pedestrian service).
- Pedestrian service:
  - PED_ACT=0: always served.
  - PED_ACT=1: ped_req[x] sets latch[x]. Side x is served for the whole x_GO+x_CLR pair if latch[x] or ped_req[x] is high in the cycle x_GO is entered.
  - On that entry the latch clears and ped_ack[x] pulses. A request in the same cycle is consumed, not re-latched.
  - An unserved side keeps its walk head red; car timing is unchanged.
  - A request during x_GO or x_CLR latches for the next cycle.
- Flash mode:
  - flash_en is sampled only on the tick that ends RED_A or RED_B. If high, the next phase is FLASH instead of x_GO.
  - In FLASH both car heads show yellow on FLASH ticks 0,2,4,… and red on odd ticks. Both walk heads are red.
  - FLASH is left on the first tick where flash_en=0, going to RED_A with a full T_ALLRED count.
  - Pedestrian latches persist through FLASH.

## Timing
- Prescaler counts 0..TICK_DIV−1. A tick is high in the cycle the count equals TICK_DIV−1. TICK_DIV=1 gives a tick every cycle.
- Each phase is held for exactly T ticks, then changes state on the clock edge after its last tick.
- phase, the lights and ped_ack are combinational decodes of registered state, so they are valid in the same cycle as the state.
- Reset values: phase 0 (6 if START_B), all lights 00, ped_ack 00, latches 0, prescaler 0, tick counter 0.
- Reset asserted mid-phase aborts the phase immediately on the next edge.
- Full cycle with defaults and TICK_DIV=1 is 70 clock cycles. With LEFT_EN=0 it is 46.
- The tick counter width must not overflow. A duration of 0 is illegal and not checked.

## Test plan
- Defaults, PED_ACT=0, TICK_DIV=1, release reset at cycle 0 → phase=1 at cycle 1; hmn_light_a=10 at cycle 15; car_light_a=10 at cycles 21–22; car_light_a=11 at cycles 23–32; phase=6 at cycle 35; phase=0 again at cycle 70.
- LEFT_EN=0 → A_YEL goes directly to RED_B; period 46 cycles; phase never 4, 5, 10 or 11.
- PED_ACT=1, no requests → hmn lights stay 00 throughout. Pulse ped_req=01 during B_GO → at the next A_GO entry ped_ack=01 for one cycle and hmn_light_a=01 for 14 cycles; the following A_GO shows red walk.
- TICK_DIV=4 → every phase lasts 4× its T in cycles; A_GO is 56 cycles.
- flash_en=1 during A_GO → sequence continues to RED_B, then phase=12 with car heads alternating 10/00 each tick. Drop flash_en → phase=0 on the next tick, then normal operation.
- Assert rst for 1 cycle mid-A_LEFT → next cycle phase=0, all lights 00, latches cleared; START_B=1 variant enters phase 6.
